// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared serial bus: grants one master, shifts in a
// serial slave-ID prefix, then holds that slave's AD_SEL for the transaction.
module bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 3,
  parameter int SID_W     = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [N_MASTERS-1:0] M_REQ,
  output logic [N_MASTERS-1:0] M_GRANT,
  input  logic                 B_BUS_OUT,
  input  logic [N_SLAVES-1:0]  S_SBSY,
  output logic [N_SLAVES-1:0]  AD_SEL,
  output logic                 B_SBSY,
  output logic                 ARB_ERR,
  output logic                 ARB_BUSY,
  output logic [2:0]           DBG_STATE
);

  localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = $clog2(SID_W + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // M_REQ/M_GRANT is a level request/grant pair: a master owns the bus from the
  // cycle M_GRANT is high until it drops M_REQ and the arbiter clears M_GRANT.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SID     = 3'd1,
    ST_SELECT  = 3'd2,
    ST_WAITBSY = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] grant_d;
  logic [N_SLAVES-1:0]  sel_d;
  logic                 err_d;
  logic [MW-1:0]        rr_q, rr_d;
  logic [SID_W-1:0]     sid_q, sid_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 seen_q, seen_d;

  logic                 win_found;
  logic [MW-1:0]        win_idx;
  logic [N_MASTERS-1:0] win_onehot;
  logic [N_SLAVES-1:0]  sid_onehot;
  logic                 owner_req;
  logic                 sel_busy;
  logic                 sid_valid;

  // First requester at or after the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      for (int m = 0; m < N_MASTERS; m++) begin
        if (!win_found && M_REQ[m] && (m == (int'(rr_q) + i) % N_MASTERS)) begin
          win_found = 1'b1;
          win_idx   = MW'(m);
        end
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int m = 0; m < N_MASTERS; m++) win_onehot[m] = (win_idx == MW'(m));
    sid_onehot = '0;
    for (int s = 0; s < N_SLAVES; s++) sid_onehot[s] = (sid_q == SID_W'(s));
  end

  // M_GRANT identifies the owner and AD_SEL the selected slave, so masking
  // avoids separate owner/slave index registers.
  assign owner_req = |(M_REQ & M_GRANT);
  assign sel_busy  = |(S_SBSY & AD_SEL);
  assign sid_valid = (32'(sid_q) < N_SLAVES);

  always_comb begin
    state_d = state_q;
    grant_d = M_GRANT;
    sel_d   = AD_SEL;
    err_d   = 1'b0;
    rr_d    = rr_q;
    sid_d   = sid_q;
    bit_d   = bit_q;
    tcnt_d  = tcnt_q;
    seen_d  = seen_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d = win_onehot;
          rr_d    = (win_idx == MW'(N_MASTERS - 1)) ? '0 : win_idx + MW'(1);
          sid_d   = '0;
          bit_d   = '0;
          state_d = ST_SID;
        end
      end
      ST_SID: begin
        if (!owner_req) begin
          state_d = ST_RELEASE;
        end else if (bit_q != CW'(SID_W)) begin
          sid_d = (sid_q << 1) | SID_W'(B_BUS_OUT);
          bit_d = bit_q + CW'(1);
        end else if (sid_valid) begin
          state_d = ST_SELECT;
        end else begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_SELECT: begin
        if (!owner_req) begin
          state_d = ST_RELEASE;
        end else begin
          sel_d   = sid_onehot;
          tcnt_d  = '0;
          seen_d  = 1'b0;
          state_d = ST_WAITBSY;
        end
      end
      ST_WAITBSY: begin
        if (!owner_req) begin
          sel_d   = '0;
          state_d = ST_RELEASE;
        end else if (sel_busy || seen_q) begin
          seen_d = 1'b1;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          sel_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_RELEASE: begin
        sel_d = '0;
        if (!owner_req && (S_SBSY == '0)) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      M_GRANT <= '0;
      AD_SEL  <= '0;
      B_SBSY  <= 1'b0;
      ARB_ERR <= 1'b0;
      rr_q    <= '0;
      sid_q   <= '0;
      bit_q   <= '0;
      tcnt_q  <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      M_GRANT <= grant_d;
      AD_SEL  <= sel_d;
      B_SBSY  <= |S_SBSY;
      ARB_ERR <= err_d;
      rr_q    <= rr_d;
      sid_q   <= sid_d;
      bit_q   <= bit_d;
      tcnt_q  <= tcnt_d;
      seen_q  <= seen_d;
    end
  end

  assign ARB_BUSY  = (state_q != ST_IDLE);
  assign DBG_STATE = state_q;

endmodule
